// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types, load funct3 codes and helpers for the writeback stage
package wb_pkg;

  // Writeback sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_e;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // True for the five load widths RV32I defines; 011, 110 and 111 are illegal
  function automatic logic is_valid_load(input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfword loads need an even byte offset
  function automatic logic is_half_load(input logic [2:0] funct3);
    return (funct3 == F3_LH) || (funct3 == F3_LHU);
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load byte/halfword select, sign/zero extension and alignment check
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  // Bring the addressed byte lane down to bit 0, then extend by load type
  always_comb begin
    shifted    = rdata >> {off, 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = shifted[15:0];
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB: begin
        data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      end
      F3_LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      F3_LW: begin
        data       = rdata;
        misaligned = (off != 2'b00);
      end
      F3_LBU: begin
        data = {{(XLEN-8){1'b0}}, byte_sel};
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = off[0];
      end
      default: begin
        data       = rdata;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - RV32I writeback stage: register-file write, load return, instret, faults
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             reg_write_i,
  input  logic [4:0]       rd_i,
  input  logic             mem_to_reg_i,
  input  logic             jal_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  pc_plus4_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic             regWrite_o,
  output logic [4:0]       wrd_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic             fault_o,
  output logic             fault_sticky_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [1:0] ST_IDLE     = IDLE;
  localparam logic [1:0] ST_WAIT_MEM = WAIT_MEM;
  localparam logic [1:0] ST_COMMIT   = COMMIT;

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  logic [1:0]       state;
  logic [4:0]       rd_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             write_q;
  logic             fault_q;
  logic             sticky_q;
  logic [TW-1:0]    tmo_cnt;
  logic [4:0]       wrd_q;
  logic [XLEN-1:0]  wdata_q;
  logic [CNT_W-1:0] instret_q;

  logic             accept;
  logic             rd_write;
  logic             load_bad;
  logic [1:0]       align_off;
  logic [2:0]       align_f3;
  logic [XLEN-1:0]  align_data;
  logic             align_mis;

  assign ready_o  = (state == ST_IDLE) && !rst_i;
  assign accept   = valid_i && ready_o;
  assign rd_write = reg_write_i && (rd_i != 5'd0);

  // In IDLE the aligner judges the incoming request; while waiting it shapes the returned word
  assign align_off = (state == ST_IDLE) ? alu_result_i[1:0] : off_q;
  assign align_f3  = (state == ST_IDLE) ? funct3_i : funct3_q;

  load_align #(
    .XLEN(XLEN)
  ) u_align (
    .rdata      (mem_rdata_i),
    .off        (align_off),
    .funct3     (align_f3),
    .data       (align_data),
    .misaligned (align_mis)
  );

  assign load_bad = !is_valid_load(funct3_i) || align_mis;

  // Instruction sequencing, result latching, retire count and fault flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      rd_q      <= 5'd0;
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      write_q   <= 1'b0;
      fault_q   <= 1'b0;
      sticky_q  <= 1'b0;
      tmo_cnt   <= '0;
      wrd_q     <= 5'd0;
      wdata_q   <= '0;
      instret_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q     <= rd_i;
            funct3_q <= funct3_i;
            off_q    <= alu_result_i[1:0];
            tmo_cnt  <= '0;
            if (!mem_to_reg_i) begin
              state     <= ST_COMMIT;
              wrd_q     <= rd_i;
              wdata_q   <= jal_i ? pc_plus4_i : alu_result_i;
              write_q   <= rd_write;
              fault_q   <= 1'b0;
              instret_q <= instret_q + CNT_W'(1);
            end else if (load_bad) begin
              // Bad width or misaligned: retire immediately as a fault, never touch memory
              state    <= ST_COMMIT;
              write_q  <= 1'b0;
              fault_q  <= 1'b1;
              sticky_q <= 1'b1;
            end else begin
              state   <= ST_WAIT_MEM;
              write_q <= rd_write;
              fault_q <= 1'b0;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (mem_rvalid_i) begin
            // A response on the timeout cycle still wins over the fault
            state     <= ST_COMMIT;
            wrd_q     <= rd_q;
            wdata_q   <= align_data;
            instret_q <= instret_q + CNT_W'(1);
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= ST_COMMIT;
            write_q  <= 1'b0;
            fault_q  <= 1'b1;
            sticky_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign regWrite_o     = (state == ST_COMMIT) && write_q;
  assign fault_o        = (state == ST_COMMIT) && fault_q;
  assign fault_sticky_o = sticky_q;
  assign wrd_o          = wrd_q;
  assign wdata_o        = wdata_q;
  assign instret_o      = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
module tb_writeback_unit;

  localparam int XLEN = 32;
  localparam int MT   = 16;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid = 1'b0;
  logic            ready;
  logic            reg_write = 1'b0;
  logic [4:0]      rd = 5'd0;
  logic            mem_to_reg = 1'b0;
  logic            jal = 1'b0;
  logic [2:0]      funct3 = 3'd0;
  logic [31:0]     alu = 32'd0;
  logic [31:0]     pc4 = 32'd0;
  logic            rvalid = 1'b0;
  logic [31:0]     rdata = 32'd0;
  logic            reg_we;
  logic [4:0]      wrd;
  logic [31:0]     wdata;
  logic            fault;
  logic            sticky;
  logic [CW-1:0]   instret;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = 32'd0;
  logic        exp_sticky  = 1'b0;

  writeback_unit #(.XLEN(XLEN), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid),
    .ready_o        (ready),
    .reg_write_i    (reg_write),
    .rd_i           (rd),
    .mem_to_reg_i   (mem_to_reg),
    .jal_i          (jal),
    .funct3_i       (funct3),
    .alu_result_i   (alu),
    .pc_plus4_i     (pc4),
    .mem_rvalid_i   (rvalid),
    .mem_rdata_i    (rdata),
    .regWrite_o     (reg_we),
    .wrd_o          (wrd),
    .wdata_o        (wdata),
    .fault_o        (fault),
    .fault_sticky_o (sticky),
    .instret_o      (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value a load of this width returns from word w at byte offset off
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] w,
                                           input logic [1:0] off);
    int unsigned b;
    int unsigned h;
    b = (w / (32'd1 << (8 * off))) % 256;
    h = (w / (32'd1 << (8 * off))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'b001:  return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'b100:  return 32'(b);
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  // Reference: load rejected before any memory access
  function automatic bit ref_pre_fault(input logic [2:0] f3, input logic [1:0] off);
    if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && (off % 2 == 1)) return 1'b1;
    if (f3 == 3'b010 && off != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  // Check the COMMIT cycle against the expectation, then the IDLE cycle after it
  task automatic check_commit(input string tag, input bit exp_fault, input bit exp_we,
                              input logic [4:0] exp_rd, input logic [31:0] exp_data);
    check({tag, ".we"}, 32'(reg_we), 32'(exp_we));
    check({tag, ".fault"}, 32'(fault), 32'(exp_fault));
    check({tag, ".ready_commit"}, 32'(ready), 32'd0);
    if (!exp_fault) begin
      check({tag, ".wrd"}, 32'(wrd), 32'(exp_rd));
      check({tag, ".wdata"}, wdata, exp_data);
    end
    if (exp_fault) exp_sticky = 1'b1;
    else exp_instret = exp_instret + 32'd1;
    tick();
    check({tag, ".we_after"}, 32'(reg_we), 32'd0);
    check({tag, ".ready_after"}, 32'(ready), 32'd1);
    check({tag, ".instret"}, instret, exp_instret);
    check({tag, ".sticky"}, 32'(sticky), 32'(exp_sticky));
  endtask

  // Issue one instruction; dly = cycles after accept when the memory answers (> MT: never)
  task automatic do_instr(input string tag, input logic rw, input logic [4:0] r,
                          input logic ld, input logic j, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] p,
                          input logic [31:0] word, input int dly);
    bit exp_we;
    exp_we     = rw && (r != 5'd0);
    valid      = 1'b1;
    reg_write  = rw;
    rd         = r;
    mem_to_reg = ld;
    jal        = j;
    funct3     = f3;
    alu        = a;
    pc4        = p;
    rvalid     = 1'b1;
    rdata      = $urandom;
    check({tag, ".ready_pre"}, 32'(ready), 32'd1);
    tick();
    valid     = 1'b0;
    rvalid    = 1'b0;
    reg_write = $urandom_range(0, 1);
    rd        = 5'($urandom);
    alu       = $urandom;
    funct3    = 3'($urandom);
    if (!ld) begin
      check_commit(tag, 1'b0, exp_we, r, j ? p : a);
    end else if (ref_pre_fault(f3, a[1:0])) begin
      check_commit(tag, 1'b1, 1'b0, r, 32'd0);
    end else begin
      for (int c = 1; c <= MT; c++) begin
        rvalid = (c == dly);
        rdata  = (c == dly) ? word : $urandom;
        tick();
        rvalid = 1'b0;
        if (c == dly) begin
          check_commit(tag, 1'b0, exp_we, r, ref_load(f3, word, a[1:0]));
          break;
        end else if (c == MT) begin
          check_commit(tag, 1'b1, 1'b0, r, 32'd0);
        end else begin
          check({tag, ".waiting_we"}, 32'(reg_we), 32'd0);
          check({tag, ".waiting_ready"}, 32'(ready), 32'd0);
        end
      end
    end
  endtask

  initial begin
    // Reset held for two edges
    rst = 1'b1;
    tick();
    tick();
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.we", 32'(reg_we), 32'd0);
    check("rst.wrd", 32'(wrd), 32'd0);
    check("rst.wdata", wdata, 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.sticky", 32'(sticky), 32'd0);
    check("rst.instret", instret, 32'd0);
    rst = 1'b0;
    #1;
    check("rst.release_ready", 32'(ready), 32'd1);
    tick();

    // Directed cases
    do_instr("add", 1'b1, 5'd5, 1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h44, 32'd0, 0);
    do_instr("jal", 1'b1, 5'd1, 1'b0, 1'b1, 3'd0, 32'h0000_0999, 32'h80, 32'd0, 0);
    do_instr("lb", 1'b1, 5'd7, 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_0000, 3);
    do_instr("lhu", 1'b1, 5'd8, 1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 32'h80FF_0000, 2);
    do_instr("x0", 1'b1, 5'd0, 1'b0, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);
    do_instr("nowrite", 1'b0, 5'd9, 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 32'h1234_5678, 1);
    do_instr("lw_mis", 1'b1, 5'd3, 1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 32'd0, 1);
    do_instr("f3_011", 1'b1, 5'd3, 1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 1);
    do_instr("lh_odd", 1'b1, 5'd4, 1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 32'd0, 1);
    do_instr("lw_edge", 1'b1, 5'd10, 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 32'hCAFE_F00D, MT);
    do_instr("timeout", 1'b1, 5'd11, 1'b1, 1'b0, 3'b000, 32'h300, 32'd0, 32'd0, MT + 1);
    do_instr("lh_neg", 1'b1, 5'd12, 1'b1, 1'b0, 3'b001, 32'h002, 32'd0, 32'h9ABC_0000, 1);

    // Randomized instruction mix
    for (int i = 0; i < 150; i++) begin
      logic [2:0] f3r;
      int         dr;
      f3r = 3'($urandom);
      dr  = (i % 10 == 0) ? MT + 1 : $urandom_range(1, MT);
      do_instr("rand", 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), f3r,
               $urandom, $urandom, $urandom, dr);
    end

    // Reset during a memory wait; the late response must be dropped
    valid      = 1'b1;
    mem_to_reg = 1'b1;
    reg_write  = 1'b1;
    rd         = 5'd6;
    funct3     = 3'b010;
    alu        = 32'h400;
    tick();
    valid = 1'b0;
    tick();
    check("midrst.waiting", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    exp_instret = 32'd0;
    exp_sticky  = 1'b0;
    rvalid      = 1'b1;
    rdata       = 32'h5555_AAAA;
    tick();
    rvalid = 1'b0;
    check("midrst.we", 32'(reg_we), 32'd0);
    check("midrst.ready", 32'(ready), 32'd1);
    tick();
    check("midrst.we2", 32'(reg_we), 32'd0);
    check("midrst.instret", instret, exp_instret);
    check("midrst.sticky", 32'(sticky), 32'(exp_sticky));
    check("midrst.wdata", wdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage of the RV32I core. Drives the register-file write port: write enable, destination register and write data.
- Accepts retiring instructions from the memory stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the returned word.
- Keeps a retired-instruction counter and reports load faults.

Parameters:
- XLEN, 32, datapath width.
- MEM_TIMEOUT, 16, maximum cycles to wait for the memory response before faulting (≥1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  memory stage presents an instruction.
- ready_o  out  1  unit can accept an instruction this cycle.
- reg_write_i  in  1  instruction writes rd.
- rd_i  in  5  destination register.
- mem_to_reg_i  in  1  instruction is a load.
- jal_i  in  1  write data is pc_plus4_i (JAL).
- funct3_i  in  3  load width/sign code.
- alu_result_i  in  XLEN  ALU result or load address.
- pc_plus4_i  in  XLEN  link value.
- mem_rvalid_i  in  1  data-memory response valid.
- mem_rdata_i  in  XLEN  data-memory response word.
- regWrite_o  out  1  register-file write strobe.
- wrd_o  out  5  register-file write address.
- wdata_o  out  XLEN  register-file write data.
- fault_o  out  1  one-cycle pulse on a load fault.
- fault_sticky_o  out  1  set by any fault; cleared only by reset.
- instret_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: while rst_i=1 at a clock edge:
  - state=IDLE, ready_o=0, regWrite_o=0, wrd_o=0, wdata_o=0.
  - fault_o=0, fault_sticky_o=0, instret_o=0, timeout counter=0.
  - A memory response arriving after a mid-wait reset is discarded.
- States: IDLE, WAIT_MEM, COMMIT.
- ready_o is 1 only in IDLE and not in reset. An accept is valid_i & ready_o at a rising edge.
- IDLE, accept of a non-load (mem_to_reg_i=0) -> COMMIT. Latch:
  - wrd_o=rd_i.
  - wdata_o = jal_i ? pc_plus4_i : alu_result_i.
  - write = reg_write_i & (rd_i!=0).
- IDLE, accept of a load:
  - Check funct3_i against the valid codes {000,001,010,100,101}; any other code is a fault.
  - Check alignment with off=alu_result_i[1:0]: halfword (001/101) with off[0]=1 is a fault; word (010) with off!=0 is a fault.
  - On a fault: go to COMMIT with write=0 and fault flagged.
  - Otherwise: go to WAIT_MEM with the timeout counter cleared.
- WAIT_MEM:
  - On mem_rvalid_i=1: select byte/halfword at off from mem_rdata_i.
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
  - Latch the result into wdata_o, then go to COMMIT with write = reg_write_i & (rd!=0).
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT-1 with no response: COMMIT with write=0 and fault flagged.
  - A response in the same cycle as the timeout is taken as data (no fault).
- COMMIT (exactly one cycle):
  - regWrite_o=write for this cycle only; it is 0 in every other state.
  - fault_o=1 if the instruction faulted; fault_sticky_o is set alongside it.
  - instret_o increments by 1 if no fault, including instructions with rd=x0 or reg_write_i=0; it wraps modulo 2^CNT_W.
  - Then go to IDLE.
- mem_rvalid_i in IDLE or COMMIT is ignored. A response in the accept cycle itself is ignored; the response must arrive ≥1 cycle later.
- Latency:
  - Non-load: accept at edge N, regWrite_o high during cycle N+1; next accept at edge N+2.
  - Load: regWrite_o high the cycle after the mem_rvalid_i edge.
- Writes to x0 are never strobed. wrd_o and wdata_o hold their last value outside COMMIT.

Decomposition:
- Package wb_pkg:
  - State enum (IDLE, WAIT_MEM, COMMIT).
  - Load funct3 constants: F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101.
  - Function is_valid_load(funct3).
- Sub-module load_align: combinational (rdata, off, funct3) -> extended XLEN data plus a misaligned flag. It is shared by the fault check and the data path.

Test Plan:
- Reset check: hold rst_i=1 for 2 cycles -> all outputs 0, ready_o=0. Release -> ready_o=1.
- Non-load ADD: rd=5, alu=0x0000_1234 -> regWrite_o=1, wrd_o=5, wdata_o=0x1234 one cycle after accept; instret_o=1. Then JAL with rd=1, pc_plus4=0x80 -> wdata_o=0x80.
- LB sign-extension: alu=0x103, rdata=0x80FF_0000, rd=7, response 3 cycles after accept -> wdata_o=0xFFFF_FF80.
- LHU: alu=0x102, same rdata -> 0x0000_80FF.
- rd=0 write: reg_write_i=1, rd=0 -> regWrite_o stays 0; instret_o still increments.
- Load faults:
  - LW at alu=0x102 -> fault_o pulse, no write, no memory wait, instret_o unchanged.
  - funct3=011 -> same response.
  - Load with no response for MEM_TIMEOUT cycles -> fault_o, fault_sticky_o=1, return to IDLE.
- Reset mid-wait: load accepted, rst_i=1 during WAIT_MEM, late mem_rvalid_i after release -> no write, state IDLE, instret_o=0.
